// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider arbiter slice:
//   - default operand width, requester count and watchdog limit
//   - FSM state encoding used by div_arbiter
//   - idxWidth(): bit width needed to index a requester vector
// -----------------------------------------------------------------------------
package div_pkg;

   // Default operand/quotient width in bits (two's complement)
   localparam int DefN = 16;

   // Default number of requesters sharing the divider
   localparam int DefNReq = 4;

   // Default maximum number of cycles spent waiting for the divider
   localparam int DefTimeout = 64;

   // One transaction at a time: accept, start the divider, wait, respond
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Width of an index into a vector of n requesters (at least one bit)
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin picker: returns the first set request bit at or after the
// pointer, wrapping around modulo NREQ.
//
// Ports:
//   req_i    in  NREQ  request vector
//   ptr_i    in  IW    search start position (0..NREQ-1)
//   grant_o  out NREQ  one-hot grant (all zero when no request)
//   idx_o    out IW    index of the granted bit (0 when no request)
//   any_o    out 1     at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
   import div_pkg::*;
#(
   parameter int NREQ = DefNReq,
   parameter int IW   = idxWidth(DefNReq)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IW-1:0]   idx_o,
   output logic            any_o
);

   // Walk the request vector starting at the pointer. The candidate position
   // is folded back into range by a single subtraction, which is enough
   // because the pointer itself is always below NREQ. The first hit wins and
   // later hits are masked by any_o.
   always_comb begin
      int          cand;
      logic [IW-1:0] candIdx;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = 0;
      candIdx = '0;
      for (int off = 0; off < NREQ; off++) begin
         cand = int'(ptr_i) + off;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         candIdx = IW'(cand);
         if (!any_o && req_i[candIdx]) begin
            any_o            = 1'b1;
            idx_o            = candIdx;
            grant_o[candIdx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
// Shares one external divider between NREQ requesters. Requests are granted
// round-robin, one transaction at a time. Each transaction is accepted in
// IDLE, issued to the divider with a one-cycle start pulse, waited on under
// a watchdog, and answered with a one-cycle response strobe to the requester
// that was granted.
//
// Ports:
//   clk           in   1       clock, all state on rising edge
//   rst           in   1       asynchronous active-high reset
//   req_valid     in   NREQ    per-requester request, held until accepted
//   req_dividend  in   NREQ*N  packed dividends, slice i for requester i
//   req_divisor   in   NREQ*N  packed divisors, slice i for requester i
//   req_ready     out  NREQ    one-hot acceptance (operands captured now)
//   rsp_valid     out  NREQ    one-hot one-cycle result strobe
//   rsp_quotient  out  N       result, zero when no rsp_valid bit is set
//   rsp_err       out  1       watchdog expired, qualified by rsp_valid
//   div_start     out  1       one-cycle start pulse to the divider
//   div_dividend  out  N       divider operand, held through the operation
//   div_divisor   out  N       divider operand, held through the operation
//   div_busy      in   1       divider status (informational only)
//   div_done      in   1       divider result strobe
//   div_quotient  in   N       divider result
// -----------------------------------------------------------------------------
module div_arbiter
   import div_pkg::*;
#(
   parameter int N       = DefN,
   parameter int NREQ    = DefNReq,
   parameter int TIMEOUT = DefTimeout
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_valid,
   input  logic [NREQ*N-1:0] req_dividend,
   input  logic [NREQ*N-1:0] req_divisor,
   output logic [NREQ-1:0]  req_ready,
   output logic [NREQ-1:0]  rsp_valid,
   output logic [N-1:0]     rsp_quotient,
   output logic             rsp_err,
   output logic             div_start,
   output logic [N-1:0]     div_dividend,
   output logic [N-1:0]     div_divisor,
   input  logic             div_busy,
   input  logic             div_done,
   input  logic [N-1:0]     div_quotient
);

   localparam int IW = idxWidth(NREQ);
   localparam int WW = $clog2(TIMEOUT + 1);

   // Watchdog value seen on the last WAIT cycle before giving up
   localparam logic [WW-1:0] WdogLast = WW'(TIMEOUT - 1);

   localparam logic [IW-1:0] LastIdx = IW'(NREQ - 1);

   state_e        state_q,    state_d;
   logic [IW-1:0] rrPtr_q,    rrPtr_d;
   logic [IW-1:0] grantIdx_q, grantIdx_d;
   logic [N-1:0]  dividend_q, dividend_d;
   logic [N-1:0]  divisor_q,  divisor_d;
   logic [N-1:0]  quot_q,     quot_d;
   logic          err_q,      err_d;
   logic [WW-1:0] wdog_q,     wdog_d;

   logic [NREQ-1:0] pickGrant;
   logic [IW-1:0]   pickIdx;
   logic            pickAny;

   // The divider's busy flag is part of the interface but the handshake is
   // fully described by div_start/div_done, so it does not steer the FSM.
   logic unusedBusy;
   assign unusedBusy = div_busy;

   // Round-robin choice among the currently valid requesters
   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) uPick (
      .req_i   (req_valid),
      .ptr_i   (rrPtr_q),
      .grant_o (pickGrant),
      .idx_o   (pickIdx),
      .any_o   (pickAny)
   );

   // Operands go to the divider straight from the capture registers, so they
   // stay stable from the start pulse until the divider answers.
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;

   // State register and datapath registers. Reset abandons any transaction
   // in flight without a response and restarts arbitration at requester 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rrPtr_q    <= '0;
         grantIdx_q <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         quot_q     <= '0;
         err_q      <= 1'b0;
         wdog_q     <= '0;
      end else begin
         state_q    <= state_d;
         rrPtr_q    <= rrPtr_d;
         grantIdx_q <= grantIdx_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         quot_q     <= quot_d;
         err_q      <= err_d;
         wdog_q     <= wdog_d;
      end
   end

   // Next-state and output logic. Outputs default to zero so the response
   // bus is quiet outside RESP and the start pulse lasts a single cycle.
   // Acceptance is suppressed while reset is asserted, because req_ready is
   // combinational and would otherwise follow req_valid during reset.
   always_comb begin
      state_d      = state_q;
      rrPtr_d      = rrPtr_q;
      grantIdx_d   = grantIdx_q;
      dividend_d   = dividend_q;
      divisor_d    = divisor_q;
      quot_d       = quot_q;
      err_d        = err_q;
      wdog_d       = wdog_q;
      req_ready    = '0;
      rsp_valid    = '0;
      rsp_quotient = '0;
      rsp_err      = 1'b0;
      div_start    = 1'b0;

      case (state_q)
         IDLE: begin
            if (pickAny && !rst) begin
               req_ready  = pickGrant;
               grantIdx_d = pickIdx;
               for (int i = 0; i < NREQ; i++) begin
                  if (pickIdx == IW'(i)) begin
                     dividend_d = req_dividend[i*N +: N];
                     divisor_d  = req_divisor[i*N +: N];
                  end
               end
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            div_start = 1'b1;
            wdog_d    = '0;
            state_d   = WAIT;
         end

         WAIT: begin
            if (div_done) begin
               quot_d  = div_quotient;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (wdog_q == WdogLast) begin
               quot_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         RESP: begin
            rsp_valid[grantIdx_q] = 1'b1;
            rsp_quotient          = quot_q;
            rsp_err               = err_q;
            rrPtr_d               = (grantIdx_q == LastIdx) ? '0 : grantIdx_q + 1'b1;
            state_d               = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_arbiter
// Self-checking bench for div_arbiter with a behavioural divider model.
// Expected responses are queued when a request is accepted and compared when
// the response strobe appears; the expected grant order is queued separately.
// -----------------------------------------------------------------------------
module tb_div_arbiter;
   import div_pkg::*;

   localparam int N       = DefN;
   localparam int NREQ    = DefNReq;
   localparam int TIMEOUT = DefTimeout;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*N-1:0] req_dividend;
   logic [NREQ*N-1:0] req_divisor;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [N-1:0]      rsp_quotient;
   logic              rsp_err;
   logic              div_start;
   logic [N-1:0]      div_dividend;
   logic [N-1:0]      div_divisor;
   logic              div_busy;
   logic              div_done;
   logic [N-1:0]      div_quotient;

   // Free-running clock
   always #5 clk = ~clk;

   div_arbiter #(
      .N       (N),
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_dividend (req_dividend),
      .req_divisor  (req_divisor),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_quotient (rsp_quotient),
      .rsp_err      (rsp_err),
      .div_start    (div_start),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_busy     (div_busy),
      .div_done     (div_done),
      .div_quotient (div_quotient)
   );

   typedef struct {
      int           idx;
      logic [N-1:0] q;
      logic         err;
      logic         hang;
   } exp_t;

   typedef struct {
      int           idx;
      logic [N-1:0] a;
      logic [N-1:0] b;
      int           lat;
      logic [N-1:0] q;
   } vec_t;

   exp_t expQ[$];
   int   orderQ[$];
   vec_t vec[6];

   logic [N-1:0]    opA[NREQ];
   logic [N-1:0]    opB[NREQ];
   logic [N-1:0]    expQuot[NREQ];
   logic [NREQ-1:0] dropMask = '0;

   int testsRun    = 0;
   int testsFailed = 0;
   int cycle       = 0;
   int acceptCycle = -100;
   int startCycle  = -100;
   int doneCycle   = -100;
   int lastIdx     = 0;
   int rspCount    = 0;
   int divCount    = 0;
   int divLat      = 3;
   int rspBefore   = 0;

   logic         divHang   = 1'b0;
   logic         prevStart = 1'b0;
   logic [N-1:0] divResult = '0;

   // Truncating signed division, zero for a zero divisor
   function automatic logic [N-1:0] modelDiv(input logic [N-1:0] a, input logic [N-1:0] b);
      logic signed [N-1:0] sa;
      logic signed [N-1:0] sb;
      logic signed [N-1:0] sq;
      sa = $signed(a);
      sb = $signed(b);
      if (sb == 0) return '0;
      sq = sa / sb;
      return sq;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic failNow(input string name);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: event not expected (cycle %0d)", name, cycle);
   endtask

   // Sample the DUT mid-cycle: acceptance, start pulse and response strobe
   task automatic checkOutput();
      int   gi;
      exp_t e;
      logic [N-1:0] q;
      gi = 0;
      if (req_ready != '0) begin
         checkVal("readyOneHot", 32'($onehot(req_ready)), 32'd1);
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
         checkVal("readyHeld", 32'(req_valid[gi]), 32'd1);
         if (orderQ.size() == 0) failNow("grantUnexpected");
         else checkVal("grantOrder", 32'(gi), 32'(orderQ.pop_front()));
         q = divHang ? '0 : expQuot[gi];
         expQ.push_back('{gi, q, divHang, divHang});
         acceptCycle = cycle;
         lastIdx     = gi;
         dropMask    = req_ready;
      end
      if (div_start) begin
         checkVal("startPulse", 32'(prevStart), 32'd0);
         checkVal("startLatency", 32'(cycle), 32'(acceptCycle + 1));
         checkVal("divDividend", 32'(div_dividend), 32'(opA[lastIdx]));
         checkVal("divDivisor", 32'(div_divisor), 32'(opB[lastIdx]));
         startCycle = cycle;
         divResult  = modelDiv(div_dividend, div_divisor);
         divCount   = divHang ? 0 : divLat;
      end
      prevStart = div_start;
      if (rsp_valid != '0) begin
         rspCount++;
         if (expQ.size() == 0) failNow("rspUnexpected");
         else begin
            e = expQ.pop_front();
            checkVal("rspValid", 32'(rsp_valid), 32'd1 << e.idx);
            checkVal("rspQuotient", 32'(rsp_quotient), 32'(e.q));
            checkVal("rspErr", 32'(rsp_err), 32'(e.err));
            if (e.hang) checkVal("timeoutLatency", 32'(cycle), 32'(startCycle + TIMEOUT + 1));
            else checkVal("doneLatency", 32'(cycle), 32'(doneCycle + 1));
         end
      end else begin
         checkVal("idleQuotient", 32'(rsp_quotient), 32'd0);
         checkVal("idleErr", 32'(rsp_err), 32'd0);
      end
   endtask

   // One clock: check at the falling edge, then update bench-driven inputs
   // (request drop after acceptance, divider model) just after the rising edge
   task automatic stepCycle();
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
      cycle++;
      req_valid = req_valid & ~dropMask;
      dropMask  = '0;
      div_done  = 1'b0;
      if (divCount > 0) begin
         divCount--;
         if (divCount == 0) begin
            div_done     = 1'b1;
            div_quotient = divResult;
            doneCycle    = cycle;
         end
      end
      div_busy = divHang || (divCount > 0);
   endtask

   task automatic applyStimulus(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [N-1:0] q);
      opA[idx]     = a;
      opB[idx]     = b;
      expQuot[idx] = q;
      req_dividend[idx*N +: N] = a;
      req_divisor[idx*N +: N]  = b;
      req_valid[idx] = 1'b1;
   endtask

   task automatic waitRsps(input int n, input int budget, input string name);
      int target;
      int k;
      target = rspCount + n;
      k = 0;
      while (rspCount < target && k < budget) begin
         stepCycle();
         k++;
      end
      checkVal(name, 32'(rspCount), 32'(target));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkVal({tag, "_reqReady"}, 32'(req_ready), 32'd0);
      checkVal({tag, "_rspValid"}, 32'(rsp_valid), 32'd0);
      checkVal({tag, "_rspQuotient"}, 32'(rsp_quotient), 32'd0);
      checkVal({tag, "_rspErr"}, 32'(rsp_err), 32'd0);
      checkVal({tag, "_divStart"}, 32'(div_start), 32'd0);
      checkVal({tag, "_divDividend"}, 32'(div_dividend), 32'd0);
      checkVal({tag, "_divDivisor"}, 32'(div_divisor), 32'd0);
   endtask

   initial begin
      vec[0] = '{0, 16'd42,     16'd8,       3, 16'd5};
      vec[1] = '{0, 16'd10,     16'd0,       2, 16'd0};
      vec[2] = '{3, -16'sd7,    16'd2,       1, -16'sd3};
      vec[3] = '{1, 16'sd32767, -16'sd1,     4, -16'sd32767};
      vec[4] = '{2, 16'h8000,   16'd1,       2, 16'h8000};
      vec[5] = '{2, 16'd1000,   16'd7,       1, 16'd142};

      rst          = 1'b1;
      req_valid    = '0;
      req_dividend = '0;
      req_divisor  = '0;
      div_busy     = 1'b0;
      div_done     = 1'b0;
      div_quotient = '0;

      // All four requesters valid while still in reset: no acceptance yet
      applyStimulus(0, -16'sd100, 16'd3,    -16'sd33);
      applyStimulus(1, 16'd100,   -16'sd3,  -16'sd33);
      applyStimulus(2, 16'd257,   16'd16,   16'd16);
      applyStimulus(3, -16'sd257, -16'sd16, 16'd16);
      divLat = 3;
      repeat (3) stepCycle();
      checkResetOutputs("reset");
      orderQ.push_back(0);
      orderQ.push_back(1);
      orderQ.push_back(2);
      orderQ.push_back(3);
      rst = 1'b0;
      waitRsps(4, 60, "allFourServed");
      checkVal("orderDrained", 32'(orderQ.size()), 32'd0);

      // Single-requester vectors
      for (int t = 0; t < 6; t++) begin
         divLat = vec[t].lat;
         applyStimulus(vec[t].idx, vec[t].a, vec[t].b, vec[t].q);
         orderQ.push_back(vec[t].idx);
         waitRsps(1, 40, "vectorRsp");
      end

      // Pointer wrap: requester 2 served, then 1 and 3 contend -> 3 first
      divLat = 2;
      applyStimulus(2, 16'd500, 16'd5, 16'd100);
      orderQ.push_back(2);
      waitRsps(1, 40, "wrapFirst");
      applyStimulus(1, 16'd81,   16'd9, 16'd9);
      applyStimulus(3, -16'sd81, 16'd9, -16'sd9);
      orderQ.push_back(3);
      orderQ.push_back(1);
      waitRsps(2, 40, "wrapPair");

      // Divider never answers: watchdog response with err set
      divHang = 1'b1;
      applyStimulus(0, 16'd1234, 16'd2, 16'd617);
      orderQ.push_back(0);
      waitRsps(1, TIMEOUT + 20, "timeoutRsp");
      divHang = 1'b0;
      repeat (2) stepCycle();

      // Reset while waiting on the divider: transaction discarded
      divLat = 30;
      applyStimulus(3, 16'd100, 16'd4, 16'd25);
      orderQ.push_back(3);
      repeat (6) stepCycle();
      checkVal("midOrderDrained", 32'(orderQ.size()), 32'd0);
      rspBefore = rspCount;
      rst = 1'b1;
      repeat (2) stepCycle();
      checkResetOutputs("midReset");
      divCount = 0;
      expQ.delete();
      rst = 1'b0;
      repeat (40) stepCycle();
      checkVal("noRspAfterReset", 32'(rspCount), 32'(rspBefore));

      // Fresh arbitration from pointer 0 after reset
      divLat = 2;
      applyStimulus(0, 16'd7, 16'd3, 16'd2);
      applyStimulus(2, 16'd7, 16'd3, 16'd2);
      orderQ.push_back(0);
      orderQ.push_back(2);
      waitRsps(2, 40, "postResetRsp");
      checkVal("expDrained", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter N, default 16, operand and quotient width in bits (two's complement).
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 64, maximum cycles in WAIT before abort.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  NREQ  per-requester operation request, held until accepted.
REQ-007 req_dividend  in  NREQ*N  packed dividends; slice i belongs to requester i.
REQ-008 req_divisor  in  NREQ*N  packed divisors; slice i belongs to requester i.
REQ-009 req_ready  out  NREQ  one-hot acceptance; operands of that requester are captured this cycle.
REQ-010 rsp_valid  out  NREQ  one-hot, one-cycle result strobe to the granted requester.
REQ-011 rsp_quotient  out  N  shared result bus, valid while any rsp_valid bit is high.
REQ-012 rsp_err  out  1  timeout flag, qualified by rsp_valid.
REQ-013 div_start  out  1  one-cycle start pulse to the shared divider.
REQ-014 div_dividend, div_divisor  out  N each  operands to the divider, stable from div_start until div_done.
REQ-015 div_busy, div_done, div_quotient  in  1,1,N  divider status and result.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; one transaction at a time.
REQ-017 IDLE: when any req_valid is set, the granted requester is the first set bit at or after rr_ptr (wrapping modulo NREQ); req_ready of that requester is high combinationally that cycle; operands are registered; next state ISSUE.
REQ-018 IDLE with no req_valid: outputs idle, state unchanged.
REQ-019 ISSUE: div_start high exactly one cycle with the registered operands; watchdog cleared; next state WAIT.
REQ-020 WAIT: div_done high registers div_quotient and moves to RESP with err=0; div_done in ISSUE is ignored.
REQ-021 WAIT: after TIMEOUT cycles without div_done, registered quotient is 0, err=1, next state RESP.
REQ-022 RESP: rsp_valid[grant]=1 for one cycle with rsp_quotient and rsp_err; rr_ptr becomes (grant+1) mod NREQ; next state IDLE.
REQ-023 Latency: acceptance at cycle T gives div_start at T+1; div_done at cycle D gives rsp_valid at D+1.
REQ-024 A requester dropping req_valid before acceptance has no effect; req_valid seen outside IDLE is not accepted.
REQ-025 Divisor 0 is forwarded unchanged; the divider's result (0) is returned with rsp_err=0.
REQ-026 Fairness: every requester that holds req_valid is served within NREQ transactions.
REQ-027 rsp_quotient and rsp_err are 0 whenever no rsp_valid bit is high.

Reset
REQ-028 rst asserted forces: state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_quotient 0, rsp_err 0, div_start 0, div_dividend 0, div_divisor 0, watchdog 0.
REQ-029 Reset mid-transaction discards the operation with no response; the first request after release gets fresh arbitration from rr_ptr 0.

Structure
REQ-030 Shared package div_pkg holds the FSM state encoding, default N, NREQ and TIMEOUT constants.
REQ-031 Round-robin grant logic lives in a sub-module rr_pick (inputs request vector and pointer, output one-hot grant and index).
REQ-032 Divider is external; div_arbiter instantiates no divider.

Verification
REQ-033 Single request: req 0 issues 42/8 -> req_ready[0] one cycle, div_start next cycle, rsp_valid[0] with quotient 5, rsp_err 0.
REQ-034 Simultaneous requests: all four valid from reset (-100/3, 100/-3, 257/16, -257/-16) -> served in order 0,1,2,3 with -33, -33, 16, 16.
REQ-035 Pointer wrap: after requester 2 is served, requesters 1 and 3 valid -> 3 served first, then 1.
REQ-036 Divide-by-zero: 10/0 -> quotient 0, rsp_err 0.
REQ-037 Timeout: divider model never asserts div_done -> rsp_valid exactly TIMEOUT+1 cycles after div_start, quotient 0, rsp_err 1.
REQ-038 Reset in WAIT: rst pulsed mid-divide -> no rsp_valid, all outputs 0; next request 7/3 returns 2.
